// File: rtl/stage4_pkg.sv
// Shared state, opcode and datapath-select encodings for the stage-4 control block.
// Pure declarations plus the opcode dispatch helper; no timing or flow control.
package stage4_pkg;

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_HALT   = 5'd3,
    S_PUSHI  = 5'd4,
    S_PUSHW  = 5'd5,
    S_ALU    = 5'd6,
    S_ALUWB  = 5'd7,
    S_SHL    = 5'd8,
    S_JMP    = 5'd9,
    S_BEQZ   = 5'd10,
    S_CALL   = 5'd11,
    S_CALLW  = 5'd12,
    S_RET    = 5'd13,
    S_DISP   = 5'd14
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_BEQZ  = 4'h8;
  localparam logic [3:0] OP_CALL  = 4'h9;
  localparam logic [3:0] OP_RET   = 4'hA;
  localparam logic [3:0] OP_DISP  = 4'hB;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSA = 3'd4;

  localparam logic [1:0] MDST_PC   = 2'd0;
  localparam logic [1:0] MDST_MSP  = 2'd1;
  localparam logic [1:0] MDST_MSPM = 2'd2;
  localparam logic [1:0] MDST_RSP  = 2'd3;

  localparam logic [2:0] MDAT_RES   = 3'd0;
  localparam logic [2:0] MDAT_SEXT  = 3'd1;
  localparam logic [2:0] MDAT_ZEXT  = 3'd2;
  localparam logic [2:0] MDAT_PC    = 3'd3;
  localparam logic [2:0] MDAT_VALA  = 3'd4;
  localparam logic [2:0] MDAT_SHIFT = 3'd5;

  // Reserved opcodes C-F behave as NOPs and return straight to FETCH.
  function automatic state_t dispatch(input logic [3:0] op);
    case (op)
      OP_HALT:                        return S_HALT;
      OP_PUSHI:                       return S_PUSHI;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  return S_ALU;
      OP_SHL:                         return S_SHL;
      OP_JMP:                         return S_JMP;
      OP_BEQZ:                        return S_BEQZ;
      OP_CALL:                        return S_CALL;
      OP_RET:                         return S_RET;
      OP_DISP:                        return S_DISP;
      default:                        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/stage4_imm_unit.sv
// Immediate sign/zero extenders and 1-bit left shifter; purely combinational, zero latency.
module stage4_imm_unit (
  input  logic [15:0] i_ir,
  input  logic [15:0] i_shift_in,
  output logic [15:0] o_sign_ext,
  output logic [15:0] o_zero_ext,
  output logic [15:0] o_shift
);

  logic w_unused_shift_msb;

  assign o_sign_ext = {{4{i_ir[11]}}, i_ir[11:0]};
  assign o_zero_ext = {4'h0, i_ir[11:0]};
  assign o_shift    = {i_shift_in[14:0], 1'b0};

  // The MSB is shifted out by design.
  assign w_unused_shift_msb = i_shift_in[15];

endmodule

// File: rtl/stage4_integration.sv
// Multicycle control FSM plus immediate unit for the 16-bit dual-stack CPU; strobes follow the registered state.
// STAGE4_PC_GUARD_EN: FETCH at PC 16'hFFFF halts instead of decoding.
module stage4_integration
  import stage4_pkg::*;
(
  input  logic        CLK,
  input  logic        CtrlRst,
  input  logic        run,
  input  logic [15:0] IROut,
  input  logic        isZero,
  input  logic [15:0] PC,
  input  logic [15:0] ShifterIn,
  output logic [15:0] SignExtOut,
  output logic [15:0] ZeroExtOut,
  output logic [15:0] ShifterOut,
  output logic [4:0]  CurrentState,
  output logic [4:0]  NextState,
  output logic        MSPWrite,
  output logic        MSPop,
  output logic        MSPRegReset,
  output logic        RSPWrite,
  output logic        RSPop,
  output logic        RSPRegReset,
  output logic        PCWrite,
  output logic        PCSource,
  output logic        PCAdd,
  output logic        PCRegReset,
  output logic        ValAWrite,
  output logic        ValBWrite,
  output logic        IRWrite,
  output logic        displayWrite,
  output logic        ResSource,
  output logic        ResWrite,
  output logic        MemRead1,
  output logic        MemRead2,
  output logic        MemWrite1,
  output logic        MemWrite2,
  output logic [1:0]  MemDst1,
  output logic [1:0]  MemDst2,
  output logic [2:0]  MemData,
  output logic [2:0]  ALUop,
  output logic        endProgram
);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_opcode;

  assign w_opcode     = IROut[15:12];
  assign CurrentState = r_state;
  assign NextState    = w_next_state;

`ifndef STAGE4_PC_GUARD_EN
  logic w_unused_pc;
  assign w_unused_pc = ^PC;
`endif

  stage4_imm_unit u_imm (
    .i_ir       (IROut),
    .i_shift_in (ShifterIn),
    .o_sign_ext (SignExtOut),
    .o_zero_ext (ZeroExtOut),
    .o_shift    (ShifterOut)
  );

  always_ff @(posedge CLK or posedge CtrlRst) begin
    if (CtrlRst) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    MSPWrite     = 1'b0;
    MSPop        = 1'b0;
    MSPRegReset  = 1'b0;
    RSPWrite     = 1'b0;
    RSPop        = 1'b0;
    RSPRegReset  = 1'b0;
    PCWrite      = 1'b0;
    PCSource     = 1'b0;
    PCAdd        = 1'b0;
    PCRegReset   = 1'b0;
    ValAWrite    = 1'b0;
    ValBWrite    = 1'b0;
    IRWrite      = 1'b0;
    displayWrite = 1'b0;
    ResSource    = 1'b0;
    ResWrite     = 1'b0;
    MemRead1     = 1'b0;
    MemRead2     = 1'b0;
    MemWrite1    = 1'b0;
    MemWrite2    = 1'b0;
    MemDst1      = MDST_PC;
    MemDst2      = MDST_PC;
    MemData      = MDAT_RES;
    ALUop        = ALU_ADD;
    endProgram   = 1'b0;

    case (r_state)
      S_IDLE: begin
        MSPRegReset = 1'b1;
        RSPRegReset = 1'b1;
        PCRegReset  = 1'b1;
        if (run) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        MemRead1 = 1'b1;
        MemDst1  = MDST_PC;
`ifdef STAGE4_PC_GUARD_EN
        if (PC == 16'hFFFF) begin
          w_next_state = S_HALT;
        end else begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_next_state = S_DECODE;
        end
`else
        IRWrite      = 1'b1;
        PCWrite      = 1'b1;
        w_next_state = S_DECODE;
`endif
      end
      S_DECODE: begin
        // RET pops its return address from the return stack; everything else reads the main stack.
        MemRead1     = 1'b1;
        MemRead2     = 1'b1;
        ValAWrite    = 1'b1;
        ValBWrite    = 1'b1;
        MemDst1      = (w_opcode == OP_RET) ? MDST_RSP : MDST_MSP;
        MemDst2      = MDST_MSPM;
        w_next_state = dispatch(w_opcode);
      end
      S_HALT: begin
        endProgram = 1'b1;
      end
      S_PUSHI: begin
        MSPWrite     = 1'b1;
        w_next_state = S_PUSHW;
      end
      S_PUSHW: begin
        MemWrite1    = 1'b1;
        MemDst1      = MDST_MSP;
        MemData      = MDAT_SEXT;
        w_next_state = S_FETCH;
      end
      S_ALU: begin
        // Opcodes 2-5 map onto ALU functions 0-3.
        ResWrite     = 1'b1;
        ALUop        = w_opcode[2:0] - 3'd2;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        MemWrite1    = 1'b1;
        MemDst1      = MDST_MSPM;
        MemData      = MDAT_RES;
        MSPWrite     = 1'b1;
        MSPop        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_SHL: begin
        MemWrite1    = 1'b1;
        MemDst1      = MDST_MSP;
        MemData      = MDAT_SHIFT;
        w_next_state = S_FETCH;
      end
      S_JMP: begin
        PCWrite      = 1'b1;
        PCAdd        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BEQZ: begin
        MSPWrite     = 1'b1;
        MSPop        = 1'b1;
        PCWrite      = isZero;
        PCAdd        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_CALL: begin
        RSPWrite     = 1'b1;
        w_next_state = S_CALLW;
      end
      S_CALLW: begin
        MemWrite2    = 1'b1;
        MemDst2      = MDST_RSP;
        MemData      = MDAT_PC;
        PCWrite      = 1'b1;
        PCAdd        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_RET: begin
        PCWrite      = 1'b1;
        PCSource     = 1'b1;
        RSPWrite     = 1'b1;
        RSPop        = 1'b1;
        w_next_state = S_FETCH;
      end
      S_DISP: begin
        displayWrite = 1'b1;
        w_next_state = S_FETCH;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stage4_integration.sv
// Randomized instruction-level bench for stage4_integration against a per-opcode micro-sequence model.
// Define STAGE4_PC_GUARD_EN for the bench and RTL together to exercise the FETCH guard.
module tb_stage4_integration;

  logic        CLK = 1'b0;
  logic        CtrlRst;
  logic        run;
  logic [15:0] IROut;
  logic        isZero;
  logic [15:0] PC;
  logic [15:0] ShifterIn;
  logic [15:0] SignExtOut, ZeroExtOut, ShifterOut;
  logic [4:0]  CurrentState, NextState;
  logic        MSPWrite, MSPop, MSPRegReset, RSPWrite, RSPop, RSPRegReset;
  logic        PCWrite, PCSource, PCAdd, PCRegReset;
  logic        ValAWrite, ValBWrite, IRWrite, displayWrite, ResSource, ResWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2;
  logic [2:0]  MemData, ALUop;
  logic        endProgram;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic msp_w, msp_pop, msp_rr, rsp_w, rsp_pop, rsp_rr;
    logic pc_w, pc_src, pc_add, pc_rr;
    logic vala_w, valb_w, ir_w, disp_w, res_src, res_w;
    logic mr1, mr2, mw1, mw2, end_p;
    logic [1:0] dst1, dst2;
    logic [2:0] mdata, aluop;
  } ctl_t;

  ctl_t act;

  stage4_integration dut (
    .CLK(CLK), .CtrlRst(CtrlRst), .run(run), .IROut(IROut), .isZero(isZero),
    .PC(PC), .ShifterIn(ShifterIn), .SignExtOut(SignExtOut), .ZeroExtOut(ZeroExtOut),
    .ShifterOut(ShifterOut), .CurrentState(CurrentState), .NextState(NextState),
    .MSPWrite(MSPWrite), .MSPop(MSPop), .MSPRegReset(MSPRegReset),
    .RSPWrite(RSPWrite), .RSPop(RSPop), .RSPRegReset(RSPRegReset),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd), .PCRegReset(PCRegReset),
    .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
    .displayWrite(displayWrite), .ResSource(ResSource), .ResWrite(ResWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData), .ALUop(ALUop),
    .endProgram(endProgram)
  );

  always #5 CLK = ~CLK;

  assign act = {MSPWrite, MSPop, MSPRegReset, RSPWrite, RSPop, RSPRegReset,
                PCWrite, PCSource, PCAdd, PCRegReset,
                ValAWrite, ValBWrite, IRWrite, displayWrite, ResSource, ResWrite,
                MemRead1, MemRead2, MemWrite1, MemWrite2, endProgram,
                MemDst1, MemDst2, MemData, ALUop};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected strobes for a state, written straight from the state table.
  function automatic ctl_t exp_ctl(input int st, input int op, input logic z, input logic guard);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.msp_rr = 1; c.rsp_rr = 1; c.pc_rr = 1; end
      1:  begin c.mr1 = 1; if (!guard) begin c.ir_w = 1; c.pc_w = 1; end end
      2:  begin c.mr1 = 1; c.mr2 = 1; c.vala_w = 1; c.valb_w = 1;
                c.dst1 = (op == 10) ? 2'd3 : 2'd1; c.dst2 = 2'd2; end
      3:  c.end_p = 1;
      4:  c.msp_w = 1;
      5:  begin c.mw1 = 1; c.dst1 = 2'd1; c.mdata = 3'd1; end
      6:  begin c.res_w = 1; c.aluop = 3'(op - 2); end
      7:  begin c.mw1 = 1; c.dst1 = 2'd2; c.msp_w = 1; c.msp_pop = 1; end
      8:  begin c.mw1 = 1; c.dst1 = 2'd1; c.mdata = 3'd5; end
      9:  begin c.pc_w = 1; c.pc_add = 1; end
      10: begin c.msp_w = 1; c.msp_pop = 1; c.pc_w = z; c.pc_add = 1; end
      11: c.rsp_w = 1;
      12: begin c.mw2 = 1; c.dst2 = 2'd3; c.mdata = 3'd3; c.pc_w = 1; c.pc_add = 1; end
      13: begin c.pc_w = 1; c.pc_src = 1; c.rsp_w = 1; c.rsp_pop = 1; end
      14: c.disp_w = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // States visited after DECODE for each opcode, before returning to FETCH.
  function automatic void micro_seq(input int op, output int q[$]);
    q = {};
    if (op == 0) q = {3};
    else if (op == 1) q = {4, 5};
    else if (op >= 2 && op <= 5) q = {6, 7};
    else if (op == 6) q = {8};
    else if (op == 7) q = {9};
    else if (op == 8) q = {10};
    else if (op == 9) q = {11, 12};
    else if (op == 10) q = {13};
    else if (op == 11) q = {14};
  endfunction

  task automatic check_state(input int st, input int op, input logic z, input int nxt, input logic guard);
    ctl_t e;
    e = exp_ctl(st, op, z, guard);
    chk($sformatf("state s%0d op%0h", st, op), 32'(CurrentState), 32'(st));
    chk($sformatf("next s%0d op%0h", st, op), 32'(NextState), 32'(nxt));
    chk($sformatf("ctl s%0d op%0h", st, op), 32'(act), 32'(e));
  endtask

  task automatic check_imm(input logic [15:0] ir, input logic [15:0] sh);
    int v;
    v = int'(ir) % 4096;
    chk("zext", 32'(ZeroExtOut), 32'(v));
    if (v >= 2048) v = v - 4096;
    chk("sext", 32'(SignExtOut), 32'(v[15:0]));
    chk("shift", 32'(ShifterOut), (32'(sh) * 2) % 65536);
  endtask

  // Starts in FETCH; returns with halted=1 if the instruction ended in HALT.
  task automatic run_instr(input logic [15:0] ir, input logic z, input logic [15:0] pc,
                           input logic [15:0] sh, output logic halted);
    int q[$];
    int op;
    logic guard;
    op = int'(ir) / 4096;
    IROut = ir; isZero = z; PC = pc; ShifterIn = sh;
    #1;
    check_imm(ir, sh);
    guard = 1'b0;
`ifdef STAGE4_PC_GUARD_EN
    guard = (pc == 16'hFFFF);
`endif
    halted = 1'b0;
    check_state(1, op, z, guard ? 3 : 2, guard);
    tick();
    if (guard) begin
      check_state(3, op, z, 3, 1'b0);
      halted = 1'b1;
      return;
    end
    micro_seq(op, q);
    check_state(2, op, z, (q.size() > 0) ? q[0] : 1, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      tick();
      check_state(q[i], op, z, (i + 1 < q.size()) ? q[i+1] : ((q[i] == 3) ? 3 : 1), 1'b0);
    end
    if (q.size() > 0 && q[q.size()-1] == 3) halted = 1'b1;
    else tick();
  endtask

  task automatic restart();
    CtrlRst = 1'b1;
    #1;
    chk("rst state", 32'(CurrentState), 32'd0);
    CtrlRst = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("restart fetch", 32'(CurrentState), 32'd1);
  endtask

  initial begin
    logic h;
    logic [15:0] ir, pc;
    CtrlRst = 1'b1; run = 1'b0; IROut = '0; isZero = 1'b0; PC = '0; ShifterIn = '0;
    repeat (2) tick();
    check_state(0, 0, 1'b0, 0, 1'b0);
    CtrlRst = 1'b0;
    repeat (3) tick();
    check_state(0, 0, 1'b0, 0, 1'b0);
    run = 1'b1;
    #1;
    chk("idle next", 32'(NextState), 32'd1);
    tick();
    run = 1'b0;
    chk("run to fetch", 32'(CurrentState), 32'd1);

    // Reset while in ALU takes effect without a clock edge.
    IROut = 16'h3000;
    tick(); tick();
    check_state(6, 3, 1'b0, 7, 1'b0);
    chk("alu sub op", 32'(ALUop), 32'd1);
    CtrlRst = 1'b1;
    #1;
    chk("async rst", 32'(CurrentState), 32'd0);
    chk("regresets", 32'({MSPRegReset, RSPRegReset, PCRegReset}), 32'd7);
    CtrlRst = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;

    IROut = 16'h1FFE;
    #1;
    chk("pushi sext", 32'(SignExtOut), 32'hFFFE);
    chk("pushi zext", 32'(ZeroExtOut), 32'h0FFE);
    run_instr(16'h1FFE, 1'b0, 16'h0010, 16'h0000, h);
    run_instr(16'h3000, 1'b0, 16'h0011, 16'h1234, h);
    run_instr(16'h8004, 1'b1, 16'h0012, 16'h0000, h);
    run_instr(16'h8004, 1'b0, 16'h0013, 16'h0000, h);
    run_instr(16'h9020, 1'b0, 16'h0014, 16'h0000, h);
    run_instr(16'hA000, 1'b0, 16'h0015, 16'h8001, h);
    chk("shl 8001", 32'(ShifterOut), 32'h0002);
    run_instr(16'h6000, 1'b0, 16'h0016, 16'h4321, h);
    run_instr(16'h7FFF, 1'b0, 16'h0017, 16'h0000, h);
    run_instr(16'hB000, 1'b0, 16'h0018, 16'h0000, h);
    run_instr(16'hC000, 1'b0, 16'h0019, 16'h0000, h);
    run_instr(16'h5800, 1'b0, 16'hFFFF, 16'h0000, h);
    if (h) restart();

    for (int n = 0; n < 250; n++) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'h0 && $urandom_range(0, 3) != 0) ir[15:12] = 4'h2;
      pc = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      run_instr(ir, 1'($urandom), pc, 16'($urandom), h);
      if (h) restart();
    end

    // HALT is sticky regardless of run.
    run_instr(16'h0123, 1'b0, 16'h0001, 16'h0000, h);
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      tick();
      chk("halt hold end", 32'(endProgram), 32'd1);
      chk("halt hold state", 32'(CurrentState), 32'd3);
    end
    restart();

`ifdef STAGE4_PC_GUARD_EN
    run_instr(16'h2000, 1'b0, 16'hFFFF, 16'h0000, h);
    chk("guard halted", 32'(h), 32'd1);
    chk("guard end", 32'(endProgram), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
